// File: rtl/mem_stage.sv
// Pipeline memory-access stage: retires ALU results and runs LDW/STW over a req/gnt/rvalid port.
// Optional `MEM_ALIGN_CHECK_EN faults misaligned LDW/STW instead of issuing them.
module mem_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [5:0]  ex_op,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_dst,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_dst,
  output logic [31:0] wb_data,
  output logic        mem_fault
);

  localparam logic [5:0] OP_LDW = 6'b001100;
  localparam logic [5:0] OP_STW = 6'b001101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state;
  logic        store_q;
  logic [4:0]  dst_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] cnt;

  logic is_mem_in;
  logic unaligned;
  logic mem_done;
  logic timeout_hit;

  assign is_mem_in = (ex_op == OP_LDW) || (ex_op == OP_STW);

`ifdef MEM_ALIGN_CHECK_EN
  assign unaligned = (ex_addr[1:0] != 2'b00);
`else
  assign unaligned = 1'b0;
`endif

  // A store finishes on grant; a load needs rvalid, either with the grant or later in WAIT.
  assign mem_done = ((state == REQ) && dm_gnt && (store_q || dm_rvalid)) ||
                    ((state == WAIT) && dm_rvalid);

  assign timeout_hit = (TIMEOUT != 0) && (cnt == 32'(TIMEOUT - 1));

  assign ex_ready = (state == IDLE);
  assign dm_req   = (state == REQ);
  assign dm_we    = (state == REQ) && store_q;
  assign dm_addr  = addr_q;
  assign dm_wdata = wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      store_q   <= 1'b0;
      dst_q     <= 5'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      cnt       <= 32'd0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_dst    <= 5'd0;
      wb_data   <= 32'd0;
      mem_fault <= 1'b0;
    end else begin
      wb_valid  <= 1'b0;
      mem_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            if (is_mem_in && !unaligned) begin
              state   <= REQ;
              cnt     <= 32'd0;
              store_q <= (ex_op == OP_STW);
              dst_q   <= ex_dst;
              addr_q  <= {ex_addr[31:2], 2'b00};
              wdata_q <= ex_store_data;
            end else begin
              // ALU ops and misaligned accesses retire straight away; r0 is never written.
              wb_valid  <= 1'b1;
              wb_dst    <= ex_dst;
              wb_data   <= is_mem_in ? 32'd0 : ex_result;
              wb_we     <= !is_mem_in && (ex_op <= 6'd11) && (ex_dst != 5'd0);
              mem_fault <= is_mem_in;
            end
          end
        end
        REQ, WAIT: begin
          if (mem_done) begin
            state    <= IDLE;
            wb_valid <= 1'b1;
            wb_dst   <= dst_q;
            wb_we    <= !store_q && (dst_q != 5'd0);
            wb_data  <= store_q ? 32'd0 : dm_rdata;
          end else if (timeout_hit) begin
            state     <= IDLE;
            wb_valid  <= 1'b1;
            wb_dst    <= dst_q;
            wb_we     <= 1'b0;
            wb_data   <= 32'd0;
            mem_fault <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
            if (dm_gnt) state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized transactions
// compared against a transaction-level reference model.
module tb_mem_stage;

  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [5:0]  ex_op;
  logic [31:0] ex_result;
  logic [31:0] ex_addr;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_dst;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic        mem_fault;

  int vectors = 0;
  int miscompares = 0;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_result(ex_result),
    .ex_addr(ex_addr), .ex_store_data(ex_store_data), .ex_dst(ex_dst),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data),
    .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    bit          we;
    logic [31:0] data;
    bit          fault;
    int          nreq;
  } exp_t;

  // Outcome of one isolated transaction, given how long memory takes to grant (gd) and answer (rd).
  function automatic exp_t model(input logic [5:0] op, input logic [4:0] dst,
                                 input logic [31:0] res, input logic [31:0] addr,
                                 input logic [31:0] rdata, input int gd, input int rd);
    exp_t e;
    int   busy;
    bit   ld = (op == 6'd12);
    e.nreq = 0; e.fault = 0; e.data = 32'd0; e.we = 0; e.lat = 1;
    if (op != 6'd12 && op != 6'd13) begin
      e.we = (op < 6'd12) && (dst != 0);
      e.data = res;
      return e;
    end
`ifdef MEM_ALIGN_CHECK_EN
    if (addr[1:0] != 2'b00) begin
      e.fault = 1;
      return e;
    end
`endif
    busy = ld ? gd + 1 + rd : gd + 1;
    if (busy > TO) begin
      e.lat = TO + 1;
      e.fault = 1;
      e.nreq = (gd + 1 > TO) ? TO : gd + 1;
    end else begin
      e.lat = busy + 1;
      e.we = ld && (dst != 0);
      e.data = ld ? rdata : 32'd0;
      e.nreq = gd + 1;
    end
    return e;
  endfunction

  // Presents one instruction (caller is at a negedge) and plays the memory side.
  // Returns at the negedge of the writeback cycle, or after a 40-cycle bound with lat = -1.
  task automatic drive_txn(input logic [5:0] op, input logic [31:0] res, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] dst, input logic [31:0] rdata,
                           input int gd, input int rd, input bit noise,
                           output int lat, output bit we, output logic [4:0] odst,
                           output logic [31:0] odata, output bit fault, output int nreq,
                           output bit stable, output bit ready_ok);
    int gcyc;
    logic [31:0] exp_addr;
    exp_addr = {addr[31:2], 2'b00};
    ready_ok = ex_ready;
    ex_valid = 1'b1; ex_op = op; ex_result = res; ex_addr = addr;
    ex_store_data = wd; ex_dst = dst;
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0;
    lat = -1; nreq = 0; stable = 1; gcyc = -1; fault = 0; we = 0; odst = 0; odata = 0;
    for (int cyc = 1; cyc <= 40 && lat < 0; cyc++) begin
      dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = $urandom;
      fault = fault | mem_fault;
      if (wb_valid) begin
        lat = cyc; we = wb_we; odst = wb_dst; odata = wb_data;
        if (!ex_ready) ready_ok = 0;
      end else if (ex_ready) begin
        ready_ok = 0;
      end
      if (lat < 0) begin
        if (dm_req) begin
          nreq++;
          if (dm_we !== (op == 6'd13) || dm_addr !== exp_addr) stable = 0;
          if (op == 6'd13 && dm_wdata !== wd) stable = 0;
          if (nreq == gd + 1) begin
            dm_gnt = 1'b1; gcyc = cyc;
          end else if (noise) begin
            dm_rvalid = 1'b1;
          end
        end
        if (gcyc >= 0 && cyc == gcyc + rd && op == 6'd12) begin
          dm_rvalid = 1'b1; dm_rdata = rdata;
        end
        @(negedge clk);
      end
    end
    dm_gnt = 1'b0; dm_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    vectors++;
    if ({ex_ready, mem_fault, dm_req, dm_we, wb_valid, wb_we} !== 6'b100000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b expected 100000",
               {ex_ready, mem_fault, dm_req, dm_we, wb_valid, wb_we});
    end
    vectors++;
    if ({dm_addr, dm_wdata, wb_data, wb_dst} !== 101'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_buses: addr %h wdata %h wb_data %h wb_dst %0d expected all zero",
               dm_addr, dm_wdata, wb_data, wb_dst);
    end
  endtask

  task automatic test_alu;
    int lat, nreq; bit we, fault, stable, rok; logic [4:0] d; logic [31:0] data;
    drive_txn(6'd0, 32'h7, 32'h0, 32'h0, 5'd3, 32'h0, 0, 0, 0,
              lat, we, d, data, fault, nreq, stable, rok);
    vectors++;
    if (lat !== 1 || we !== 1'b1 || d !== 5'd3 || data !== 32'h7 || fault !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL alu_add: got lat %0d we %0d dst %0d data %h fault %0d expected 1 1 3 00000007 0",
               lat, we, d, data, fault);
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0]  ops [10];
    logic [31:0] res [10];
    logic [4:0]  dst [10];
    for (int i = 0; i < 10; i++) begin
      do ops[i] = 6'($urandom_range(0, 63)); while (ops[i] == 6'd12 || ops[i] == 6'd13);
      res[i] = $urandom;
      dst[i] = 5'($urandom_range(0, 31));
    end
    for (int i = 0; i < 10; i++) begin
      ex_valid = 1'b1; ex_op = ops[i]; ex_result = res[i]; ex_dst = dst[i];
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (wb_valid !== 1'b1 || ex_ready !== 1'b1 || wb_dst !== dst[i] ||
          wb_we !== ((ops[i] < 6'd12) && (dst[i] != 0)) ||
          (wb_we === 1'b1 && wb_data !== res[i])) begin
        miscompares++;
        $display("[TB] FAIL b2b_%0d op %0d: got valid %0d ready %0d we %0d dst %0d data %h, want data %h dst %0d",
                 i, ops[i], wb_valid, ex_ready, wb_we, wb_dst, wb_data, res[i], dst[i]);
      end
    end
    ex_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (wb_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_idle: got wb_valid %0d expected 0", wb_valid);
    end
  endtask

  task automatic test_store;
    int lat, nreq; bit we, fault, stable, rok; logic [4:0] d; logic [31:0] data;
    drive_txn(6'd13, 32'h0, 32'h100, 32'hDEADBEEF, 5'd7, 32'h0, 2, 0, 0,
              lat, we, d, data, fault, nreq, stable, rok);
    vectors++;
    if (nreq !== 3 || stable !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stw_req: got %0d req cycles stable %0d expected 3 stable 1", nreq, stable);
    end
    vectors++;
    if (lat !== 4 || we !== 1'b0 || rok !== 1'b1 || fault !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stw_wb: got lat %0d we %0d ready_ok %0d fault %0d expected 4 0 1 0",
               lat, we, rok, fault);
    end
  endtask

  task automatic test_load;
    int lat, nreq; bit we, fault, stable, rok; logic [4:0] d; logic [31:0] data;
    drive_txn(6'd12, 32'h0, 32'h40, 32'h0, 5'd5, 32'h12345678, 0, 0, 0,
              lat, we, d, data, fault, nreq, stable, rok);
    vectors++;
    if (lat !== 2 || we !== 1'b1 || d !== 5'd5 || data !== 32'h12345678 || nreq !== 1) begin
      miscompares++;
      $display("[TB] FAIL ldw_fast: got lat %0d we %0d dst %0d data %h nreq %0d expected 2 1 5 12345678 1",
               lat, we, d, data, nreq);
    end
    drive_txn(6'd12, 32'h0, 32'h80, 32'h0, 5'd0, 32'hCAFEF00D, 0, 4, 1,
              lat, we, d, data, fault, nreq, stable, rok);
    vectors++;
    if (lat !== 6 || we !== 1'b0 || d !== 5'd0 || fault !== 1'b0 || rok !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ldw_r0: got lat %0d we %0d dst %0d fault %0d ready_ok %0d expected 6 0 0 0 1",
               lat, we, d, fault, rok);
    end
  endtask

  task automatic test_timeout;
    int lat, nreq; bit we, fault, stable, rok; logic [4:0] d; logic [31:0] data;
    drive_txn(6'd13, 32'h0, 32'h200, 32'h55AA55AA, 5'd9, 32'h0, 99, 0, 0,
              lat, we, d, data, fault, nreq, stable, rok);
    vectors++;
    if (lat !== TO + 1 || fault !== 1'b1 || we !== 1'b0 || nreq !== TO) begin
      miscompares++;
      $display("[TB] FAIL timeout: got lat %0d fault %0d we %0d nreq %0d expected %0d 1 0 %0d",
               lat, fault, we, nreq, TO + 1, TO);
    end
    vectors++;
    if (dm_req !== 1'b0 || ex_ready !== 1'b1 || mem_fault !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL timeout_state: got req %0d ready %0d fault %0d expected 0 1 1",
               dm_req, ex_ready, mem_fault);
    end
    dm_rvalid = 1'b1; dm_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    dm_rvalid = 1'b0;
    @(negedge clk);
    vectors++;
    if (wb_valid !== 1'b0 || mem_fault !== 1'b0 || ex_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL late_rvalid: got wb_valid %0d fault %0d ready %0d expected 0 0 1",
               wb_valid, mem_fault, ex_ready);
    end
  endtask

  task automatic test_reset_mid_wait;
    ex_valid = 1'b1; ex_op = 6'd12; ex_addr = 32'h300; ex_dst = 5'd4;
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0;
    dm_gnt = 1'b1;
    @(negedge clk);
    dm_gnt = 1'b0;
    vectors++;
    if (dm_req !== 1'b0 || ex_ready !== 1'b0 || wb_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wait_entry: got req %0d ready %0d wb_valid %0d expected 0 0 0",
               dm_req, ex_ready, wb_valid);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (dm_req !== 1'b0 || ex_ready !== 1'b1 || wb_valid !== 1'b0 || mem_fault !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_in_wait: got req %0d ready %0d wb_valid %0d fault %0d expected 0 1 0 0",
               dm_req, ex_ready, wb_valid, mem_fault);
    end
    @(negedge clk);
    rst = 1'b0;
    dm_rvalid = 1'b1; dm_rdata = 32'h11111111;
    @(negedge clk);
    dm_rvalid = 1'b0;
    vectors++;
    if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL post_rst_rvalid: got wb_valid %0d ready %0d expected 0 1", wb_valid, ex_ready);
    end
  endtask

  task automatic test_align;
    int lat, nreq; bit we, fault, stable, rok; logic [4:0] d; logic [31:0] data;
    exp_t e;
    e = model(6'd12, 5'd6, 32'h0, 32'h102, 32'h0BADF00D, 0, 0);
    drive_txn(6'd12, 32'h0, 32'h102, 32'h0, 5'd6, 32'h0BADF00D, 0, 0, 0,
              lat, we, d, data, fault, nreq, stable, rok);
    vectors++;
    if (lat !== e.lat || fault !== e.fault || nreq !== e.nreq || we !== e.we || stable !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL unaligned_ldw: got lat %0d fault %0d nreq %0d we %0d stable %0d expected %0d %0d %0d %0d 1",
               lat, fault, nreq, we, stable, e.lat, e.fault, e.nreq, e.we);
    end
  endtask

  task automatic test_random;
    int lat, nreq, gd, rd; bit we, fault, stable, rok; logic [4:0] d; logic [31:0] data;
    logic [5:0] op; logic [31:0] res, addr, wd, rdata; logic [4:0] dst;
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: op = 6'd12;
        1: op = 6'd13;
        default: do op = 6'($urandom_range(0, 63)); while (op == 6'd12 || op == 6'd13);
      endcase
      res = $urandom; addr = $urandom; wd = $urandom; rdata = $urandom;
      dst = 5'($urandom_range(0, 31));
      gd = ($urandom_range(0, 7) == 0) ? 99 : $urandom_range(0, 3);
      rd = $urandom_range(0, 3);
      e = model(op, dst, res, addr, rdata, gd, rd);
      drive_txn(op, res, addr, wd, dst, rdata, gd, rd, 1'($urandom_range(0, 1)),
                lat, we, d, data, fault, nreq, stable, rok);
      vectors++;
      if (lat !== e.lat || we !== e.we || d !== dst || fault !== e.fault || nreq !== e.nreq ||
          stable !== 1'b1 || rok !== 1'b1 || (e.we && data !== e.data)) begin
        miscompares++;
        $display("[TB] FAIL rand_%0d op %0d gd %0d rd %0d: got lat %0d we %0d dst %0d data %h fault %0d nreq %0d stable %0d rdy %0d; want lat %0d we %0d dst %0d data %h fault %0d nreq %0d",
                 i, op, gd, rd, lat, we, d, data, fault, nreq, stable, rok,
                 e.lat, e.we, dst, e.data, e.fault, e.nreq);
      end
    end
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_op = 6'd0; ex_result = 32'd0; ex_addr = 32'd0;
    ex_store_data = 32'd0; ex_dst = 5'd0; dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'd0;
    #2;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_alu();
    test_back_to_back();
    test_store();
    test_load();
    test_timeout();
    test_align();
    test_random();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Pipeline memory-access stage sitting directly downstream of the execute-stage ALU. It accepts one executed instruction per handshake, passes ALU results straight to writeback, and runs LDW/STW against a single-port data memory through a request/grant/rvalid handshake. While a memory access is outstanding it stalls the execute stage. It delivers exactly one writeback record per accepted instruction.

## Interface
Parameters:
- `TIMEOUT`, default 255: cycles allowed in REQ+WAIT before abort; 0 disables the timeout.

Ports:
- `clk`  in  1  pipeline clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ex_valid`  in  1  execute stage presents an instruction
- `ex_ready`  out  1  stage can accept; high only in IDLE
- `ex_op`  in  6  opcode, same encoding as the ALU
- `ex_result`  in  32  ALU `rd` result
- `ex_addr`  in  32  ALU effective address `A` (LDW/STW)
- `ex_store_data`  in  32  rt value for STW
- `ex_dst`  in  5  destination register index
- `dm_req`  out  1  memory request, held until granted
- `dm_we`  out  1  1 = store, 0 = load
- `dm_addr`  out  32  memory byte address
- `dm_wdata`  out  32  store data
- `dm_gnt`  in  1  memory accepts request this cycle
- `dm_rvalid`  in  1  load data valid
- `dm_rdata`  in  32  load data
- `wb_valid`  out  1  one-cycle writeback record
- `wb_we`  out  1  register write enable
- `wb_dst`  out  5  register index
- `wb_data`  out  32  write data
- `mem_fault`  out  1  one-cycle fault pulse

## Operation
- Accept: `ex_valid && ex_ready` at a rising edge. On accept, latch op, result, addr, store data and dst.
- FSM states are IDLE, REQ and WAIT.
- IDLE, accepting a non-memory op: stay in IDLE and emit a writeback on the next cycle.
- IDLE, accepting LDW (001100) or STW (001101): go to REQ.
- REQ: `dm_req`=1, with `dm_we`, `dm_addr` and `dm_wdata` held stable.
  - On `dm_gnt` with STW: writeback (`wb_we`=0), then IDLE.
  - On `dm_gnt` with LDW: if `dm_rvalid` is also high, complete the load; otherwise go to WAIT.
- WAIT: on `dm_rvalid`, writeback with `wb_data`=`dm_rdata`, then IDLE.
- `dm_rvalid` is ignored in IDLE, and in REQ without `dm_gnt`.
- `wb_we`=1 for ops 000000–001011 and for LDW, with `wb_data`=`ex_result` for ALU ops.
- `wb_we`=0 for STW, BZ, BEQ, JR, unknown ops, and any op with dst=0 (r0 never written).
- Timeout: a counter clears on entering REQ and increments in REQ/WAIT. When it reaches `TIMEOUT`:
  - pulse `mem_fault`;
  - emit a writeback with `wb_we`=0;
  - drop `dm_req`;
  - return to IDLE.
- Reset (async, any state, including mid-access): state IDLE, counter 0.
- Output values during reset: `ex_ready`=1 and `mem_fault`=0; `dm_req`, `dm_we`, `dm_addr`, `dm_wdata`, `wb_valid`, `wb_we`, `wb_dst` and `wb_data` are all 0.

## Timing
- All outputs are registered or decoded from state. No combinational path from `dm_*` inputs to `dm_req`.
- Non-memory op accepted at edge N: `wb_valid` high during cycle N+1. Throughput is one per cycle.
- LDW/STW accepted at edge N: `dm_req` high from cycle N+1. `ex_ready`=0 from N+1 until the cycle after completion.
- Grant sampled at edge G:
  - STW: `wb_valid` in G+1.
  - LDW with same-cycle `dm_rvalid`: `wb_valid` in G+1. Minimum load latency is accept N → writeback N+2.
  - LDW otherwise: `dm_rvalid` sampled at edge R gives `wb_valid` in R+1.
- `dm_req` deasserts in the cycle after the grant edge.
- `wb_valid` and `mem_fault` are single-cycle pulses. Writeback has no backpressure.
- `ex_ready` returns high in the same cycle as the completing `wb_valid`. A new accept is possible at the end of that cycle.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - LDW/STW with `ex_addr[1:0]`≠0 issues no memory request.
  - Instead: `mem_fault` pulses and `wb_valid` fires with `wb_we`=0, one cycle after accept (like a non-memory op).
- `MEM_ALIGN_CHECK_EN` undefined:
  - `dm_addr` = {`ex_addr[31:2]`, 2'b00}; low bits are silently dropped.
  - `mem_fault` is driven only by the timeout.

## Test plan
- ADD: op=000000, result=0x0000_0007, dst=3 → next cycle `wb_valid`=1, `wb_we`=1, `wb_dst`=3, `wb_data`=7. Back-to-back ops retire one per cycle.
- STW: addr=0x100, data=0xDEAD_BEEF, gnt after 2 cycles → `dm_req` held 3 cycles with `dm_we`=1 and stable address/data. Then `wb_valid` with `wb_we`=0; `ex_ready` low throughout.
- LDW: addr=0x40, dst=5, gnt with same-cycle rvalid, rdata=0x1234_5678 → `wb_data`=0x1234_5678, `wb_dst`=5, writeback 2 cycles after accept.
- LDW, dst=0, rvalid 4 cycles after gnt → `wb_valid`=1 with `wb_we`=0. Writes nothing.
- TIMEOUT=4, never grant → `mem_fault` pulses after 4 REQ cycles, `dm_req` drops, `wb_we`=0, `ex_ready`=1. A later rvalid is ignored.
- Assert `rst` in WAIT → `dm_req`=0, `ex_ready`=1, no writeback. With `MEM_ALIGN_CHECK_EN`, LDW at addr 0x102 → `mem_fault`=1, no `dm_req`.
